// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer and count-tick prescaler for the stopwatch counter chain.
// Optional lap view is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
   parameter int DIV = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_stop,
   input  logic       lap,
   input  logic       clear,
   input  logic       chain_tc,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       freeze,
   output logic       running,
   output logic       ovf,
   output logic [1:0] state
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [PW-1:0]   pre_r;
   logic [PW-1:0]   pre_nxt_s;
   logic            ss_q_r;
   logic            clr_q_r;
   logic            cnt_en_r;
   logic            cnt_clr_r;
   logic            freeze_r;
   logic            running_r;
   logic            ovf_r;
   logic            ovf_nxt_s;
   logic            tick_s;
   logic            clr_pulse_s;
   logic            active_s;
   logic            ev_ss_s;
   logic            ev_clr_s;
   logic            ev_lap_s;

   assign ev_ss_s  = start_stop & ~ss_q_r;
   assign ev_clr_s = clear & ~clr_q_r;

`ifdef STOPWATCH_LAP_EN
   logic lap_q_r;
   assign ev_lap_s = lap & ~lap_q_r;

   // Lap button edge register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lap_q_r <= 1'b0;
      end else begin
         lap_q_r <= lap;
      end
   end
`else
   logic unused_lap_s;
   assign unused_lap_s = lap;
   assign ev_lap_s     = 1'b0;
`endif

   assign active_s = (state_r == RUN) || (state_r == LAP);

   // Next-state, prescaler and pulse decode; the prescaler acts on the current state, so a wrap
   // coinciding with a pause still produces its tick.
   always_comb begin
      state_nxt_s = state_r;
      pre_nxt_s   = pre_r;
      ovf_nxt_s   = ovf_r;
      tick_s      = 1'b0;
      clr_pulse_s = 1'b0;

      if (active_s) begin
         if (pre_r == PW'(DIV - 1)) begin
            pre_nxt_s = {PW{1'b0}};
            tick_s    = 1'b1;
         end else begin
            pre_nxt_s = pre_r + PW'(1);
         end
      end else begin
         pre_nxt_s = pre_r;
      end

      // Only the highest-priority event is considered; if the state ignores it, nothing happens.
      case (state_r)
         IDLE: begin
            if (ev_clr_s) begin
               clr_pulse_s = 1'b1;
            end else if (ev_ss_s) begin
               state_nxt_s = RUN;
               pre_nxt_s   = {PW{1'b0}};
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (chain_tc) begin
               state_nxt_s = PAUSE;
               ovf_nxt_s   = 1'b1;
            end else if (ev_clr_s) begin
               state_nxt_s = RUN;
            end else if (ev_ss_s) begin
               state_nxt_s = PAUSE;
            end else if (ev_lap_s) begin
               state_nxt_s = LAP;
            end else begin
               state_nxt_s = RUN;
            end
         end
         LAP: begin
            if (chain_tc) begin
               state_nxt_s = PAUSE;
               ovf_nxt_s   = 1'b1;
            end else if (ev_clr_s) begin
               state_nxt_s = LAP;
            end else if (ev_ss_s) begin
               state_nxt_s = PAUSE;
            end else if (ev_lap_s) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = LAP;
            end
         end
         PAUSE: begin
            if (ev_clr_s) begin
               state_nxt_s = IDLE;
               clr_pulse_s = 1'b1;
               ovf_nxt_s   = 1'b0;
               pre_nxt_s   = {PW{1'b0}};
            end else if (ev_ss_s) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = PAUSE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            pre_nxt_s   = {PW{1'b0}};
         end
      endcase
   end

   // State, prescaler, edge registers and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         pre_r     <= {PW{1'b0}};
         ss_q_r    <= 1'b0;
         clr_q_r   <= 1'b0;
         cnt_en_r  <= 1'b0;
         cnt_clr_r <= 1'b0;
         freeze_r  <= 1'b0;
         running_r <= 1'b0;
         ovf_r     <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         pre_r     <= pre_nxt_s;
         ss_q_r    <= start_stop;
         clr_q_r   <= clear;
         cnt_en_r  <= tick_s;
         cnt_clr_r <= clr_pulse_s;
         freeze_r  <= (state_nxt_s == LAP);
         running_r <= (state_nxt_s == RUN) || (state_nxt_s == LAP);
         ovf_r     <= ovf_nxt_s;
      end
   end

   assign cnt_en  = cnt_en_r;
   assign cnt_clr = cnt_clr_r;
   assign freeze  = freeze_r;
   assign running = running_r;
   assign ovf     = ovf_r;
   assign state   = state_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=4: vector table plus multi-cycle sequences.
module tb_stopwatch_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start_stop;
   logic       lap;
   logic       clear;
   logic       chain_tc;
   logic       cnt_en;
   logic       cnt_clr;
   logic       freeze;
   logic       running;
   logic       ovf;
   logic [1:0] state;

   int checks;
   int errors;

   stopwatch_ctrl #(.DIV(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_stop (start_stop),
      .lap        (lap),
      .clear      (clear),
      .chain_tc   (chain_tc),
      .cnt_en     (cnt_en),
      .cnt_clr    (cnt_clr),
      .freeze     (freeze),
      .running    (running),
      .ovf        (ovf),
      .state      (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       rn;
      logic       ss;
      logic       lp;
      logic       cl;
      logic       tc;
      logic [1:0] st;
      logic       en;
      logic       clr;
      logic       fz;
      logic       run;
      logic       ov;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rn, input logic ss, input logic lp, input logic cl,
                      input logic tc, input logic [1:0] st, input logic en, input logic clr,
                      input logic fz, input logic run, input logic ov);
      vec_t v;
      v = '{rn, ss, lp, cl, tc, st, en, clr, fz, run, ov};
      tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   localparam logic [1:0] LAP_ST = 
`ifdef STOPWATCH_LAP_EN
      2'd3;
`else
      2'd1;
`endif
   localparam logic LAP_FZ =
`ifdef STOPWATCH_LAP_EN
      1'b1;
`else
      1'b0;
`endif

   initial begin
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      start_stop = 1'b0;
      lap        = 1'b0;
      clear      = 1'b0;
      chain_tc   = 1'b0;

      //   rn    ss    lp    cl    tc    st    en    clr   fz    run   ov
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // clear and start_stop together in PAUSE: clear wins, start_stop dropped
      add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // overflow while running, tc held into PAUSE, resume keeps ovf
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      // pause on the wrap edge still emits the final tick
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // chain_tc beats a lap event on the same edge
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // reset on the wrap edge drops the pending tick
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // chain_tc in IDLE is ignored
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         rst_n      = tbl[i].rn;
         start_stop = tbl[i].ss;
         lap        = tbl[i].lp;
         clear      = tbl[i].cl;
         chain_tc   = tbl[i].tc;
         tick();
         checks++;
         if ({state, cnt_en, cnt_clr, freeze, running, ovf} !==
             {tbl[i].st, tbl[i].en, tbl[i].clr, tbl[i].fz, tbl[i].run, tbl[i].ov}) begin
            errors++;
            $display("FAIL row%0d: got st=%0d en=%0b clr=%0b fz=%0b run=%0b ov=%0b expected st=%0d en=%0b clr=%0b fz=%0b run=%0b ov=%0b",
                     i, state, cnt_en, cnt_clr, freeze, running, ovf,
                     tbl[i].st, tbl[i].en, tbl[i].clr, tbl[i].fz, tbl[i].run, tbl[i].ov);
         end
      end

      // start_stop held 20 cycles from IDLE: ticks at cycles 5, 9, 13, 17
      start_stop = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         check($sformatf("held_state_c%0d", c), state, 1);
         check($sformatf("held_en_c%0d", c), cnt_en, (c == 5 || c == 9 || c == 13 || c == 17) ? 1 : 0);
      end
      start_stop = 1'b0;
      tick();
      check("wrap_c21", cnt_en, 1);
      tick();
      tick();
      // prescaler now at 2: pause without a tick
      start_stop = 1'b1;
      tick();
      check("pause_state", state, 2);
      check("pause_en", cnt_en, 0);
      start_stop = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         check($sformatf("paused_en_%0d", c), cnt_en, 0);
      end
      check("paused_state", state, 2);
      start_stop = 1'b1;
      tick();
      check("resume_state", state, 1);
      check("resume_en0", cnt_en, 0);
      start_stop = 1'b0;
      tick();
      check("resume_en1", cnt_en, 1);

      // lap view while counting continues
      lap = 1'b1;
      tick();
      check("lap_state", state, int'(LAP_ST));
      check("lap_freeze", freeze, int'(LAP_FZ));
      check("lap_running", running, 1);
      lap = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         check($sformatf("lap_en_%0d", c), cnt_en, (c == 3 || c == 7) ? 1 : 0);
         check($sformatf("lap_hold_%0d", c), state, int'(LAP_ST));
      end
      lap = 1'b1;
      tick();
      check("unlap_state", state, 1);
      check("unlap_freeze", freeze, 0);
      lap = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
